// File: rtl/tdm_demux8.sv
// tdm_demux8: 1-to-8 time-division demultiplexer.
// Collects successive serial bits into a shadow register, starting at a
// slot-0 sync marker, and delivers each complete frame atomically on a
// parallel output with a one-cycle frame_valid strobe. Sync protocol
// violations (early or missing sync) raise a one-cycle sync_err.
// Optional build macro TDM_PARITY_EN: the frame gains a ninth slot that
// carries even parity over slots 0..7. A frame with bad parity is dropped
// and flagged on parity_err.
module tdm_demux8 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             sync,
  output logic [7:0]       out,
  output logic             frame_valid,
  output logic             locked,
`ifdef TDM_PARITY_EN
  output logic [3:0]       slot,
  output logic             parity_err,
`else
  output logic [2:0]       slot,
`endif
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_cnt
);

`ifdef TDM_PARITY_EN
  localparam int SLOT_W = 4;
  localparam int SH_W   = 8;
`else
  localparam int SLOT_W = 3;
  localparam int SH_W   = 7;
`endif

  // The slot that completes a frame: 7 for a plain frame, 8 when the
  // parity slot follows the data.
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SH_W);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [SH_W-1:0]    shadow_q, shadow_d;
  logic [7:0]         out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fv_q, fv_d;
  logic               serr_q, serr_d;
  logic               perr_q, perr_d;

  // Next-state logic: slot sequencing, shadow capture and frame delivery.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    fv_d     = 1'b0;
    serr_d   = 1'b0;
    perr_d   = 1'b0;
    if (en) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_d    = '0;
            shadow_d[0] = din;
            slot_d      = SLOT_W'(1);
            state_d     = LOCKED;
          end
        end
        default: begin
          if (slot_q == '0) begin
            if (sync) begin
              shadow_d    = '0;
              shadow_d[0] = din;
              slot_d      = SLOT_W'(1);
            end else begin
              // Missed sync: drop lock; this bit cannot be placed.
              serr_d  = 1'b1;
              state_d = HUNT;
              slot_d  = '0;
            end
          end else if (sync) begin
            // Early sync: the partial frame is abandoned and this bit
            // starts a fresh frame.
            serr_d      = 1'b1;
            shadow_d    = '0;
            shadow_d[0] = din;
            slot_d      = SLOT_W'(1);
          end else if (slot_q == LAST_SLOT) begin
`ifdef TDM_PARITY_EN
            if (^{shadow_q, din} == 1'b0) begin
              out_d = shadow_q;
              fv_d  = 1'b1;
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              perr_d = 1'b1;
            end
`else
            out_d = {din, shadow_q};
            fv_d  = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
`endif
            slot_d = '0;
          end else begin
            for (int k = 1; k < SH_W; k++) begin
              if (slot_q == SLOT_W'(k)) shadow_d[k] = din;
            end
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      endcase
    end
  end

  // State and registered outputs; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      shadow_q <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      fv_q     <= 1'b0;
      serr_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      fv_q     <= fv_d;
      serr_q   <= serr_d;
      perr_q   <= perr_d;
    end
  end

  assign out         = out_q;
  assign frame_valid = fv_q;
  assign sync_err    = serr_q;
  assign locked      = (state_q == LOCKED);
  assign slot        = slot_q;
  assign frame_cnt   = cnt_q;
`ifdef TDM_PARITY_EN
  assign parity_err  = perr_q;
`else
  // perr_q only carries information in the parity build.
  logic unused_perr;
  assign unused_perr = perr_q;
`endif

endmodule
